// File: rtl/splash_overlay_seq_pkg.sv
// Shared definitions for the splash overlay sequencer.
// FSM encoding, glyph code width and glyph cell geometry.
package splash_overlay_seq_pkg;

    localparam int unsigned CODE_W   = 6;
    localparam int unsigned COORD_W  = 12;
    localparam int unsigned EXT_W    = COORD_W + 1;
    localparam int unsigned BLOCK_SH = 4;
    localparam int unsigned CELL_W   = 8 << BLOCK_SH;
    localparam int unsigned CELL_H   = 8 << BLOCK_SH;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REVEAL = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;
    localparam state_t ST_BLINK  = 2'd3;

    // Block rows 0..5 are bars selected by code bits; columns 0 and 7 are margins.
    function automatic logic glyph_bit(
        input logic [CODE_W-1:0] code,
        input logic [2:0]        row,
        input logic [2:0]        col
    );
        logic lit;
        lit = 1'b0;
        if (row < 3'd6 && col != 3'd0 && col != 3'd7) begin
            lit = code[row];
        end
        return lit;
    endfunction

endpackage

// File: rtl/splash_overlay_seq_glyph_slot_render.sv
// One large-glyph slot: pixel hit test against a 128x128 cell.
// Origin is fixed per instance; the code selects the bar pattern.
module glyph_slot_render
    import splash_overlay_seq_pkg::*;
#(
    parameter int unsigned ORG_X = 0,
    parameter int unsigned ORG_Y = 0
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [CODE_W-1:0]  code_i,
    output logic               hit_o
);

    localparam logic [EXT_W-1:0] OX = EXT_W'(ORG_X);
    localparam logic [EXT_W-1:0] OY = EXT_W'(ORG_Y);

    logic [EXT_W-1:0] dx;
    logic [EXT_W-1:0] dy;
    logic             in_x;
    logic             in_y;

    // Cell-relative offset, bounds check and glyph block lookup.
    always_comb begin
        dx    = {1'b0, x_i} - OX;
        dy    = {1'b0, y_i} - OY;
        in_x  = ({1'b0, x_i} >= OX) && (dx < EXT_W'(CELL_W));
        in_y  = ({1'b0, y_i} >= OY) && (dy < EXT_W'(CELL_H));
        hit_o = in_x && in_y &&
                glyph_bit(code_i, dy[BLOCK_SH +: 3], dx[BLOCK_SH +: 3]);
    end

endmodule

// File: rtl/splash_overlay_seq.sv
// Splash screen sequencer: reveals glyph slots, holds, optionally blinks.
// Define SPLASH_BLINK_EN to include the exit blink phase.
module splash_overlay_seq
    import splash_overlay_seq_pkg::*;
#(
    parameter int unsigned NUM_CHARS     = 7,
    parameter int unsigned ORIGIN_X      = 100,
    parameter int unsigned ORIGIN_Y      = 128,
    parameter int unsigned CHAR_PITCH    = 160,
    parameter int unsigned REVEAL_FRAMES = 4,
    parameter int unsigned HOLD_FRAMES   = 600,
    parameter int unsigned BLINK_FRAMES  = 30,
    parameter int unsigned BLINK_CYCLES  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CODE_W*NUM_CHARS-1:0] char_codes,
    input  logic [COORD_W-1:0]          VGA_HORZ_COORD,
    input  logic [COORD_W-1:0]          VGA_VERT_COORD,
    output logic                        overlay_on,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned MAX_RH = (REVEAL_FRAMES > HOLD_FRAMES) ?
                                     REVEAL_FRAMES : HOLD_FRAMES;
`ifdef SPLASH_BLINK_EN
    localparam int unsigned MAX_F   = (BLINK_FRAMES > MAX_RH) ?
                                      BLINK_FRAMES : MAX_RH;
    localparam int unsigned TOGGLES = 2 * BLINK_CYCLES;
    localparam int unsigned TOG_W   = $clog2(TOGGLES + 1);
`else
    localparam int unsigned MAX_F   = MAX_RH;
`endif
    localparam int unsigned CNT_W = $clog2(MAX_F + 1);
    localparam int unsigned SH_W  = $clog2(NUM_CHARS + 1);
    localparam int unsigned CC_W  = CODE_W * NUM_CHARS;

    if (NUM_CHARS < 1 || NUM_CHARS > 16 || REVEAL_FRAMES < 1 ||
        HOLD_FRAMES < 1 || BLINK_FRAMES < 1 || BLINK_CYCLES < 1) begin : g_bad_cfg
        $error("splash_overlay_seq: parameter out of range");
    end

    state_t               state_q, state_d;
    logic [SH_W-1:0]      shown_q, shown_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CC_W-1:0]      codes_q, codes_d;
    logic                 done_q, done_d;
    logic                 ovl_q, ovl_d;
    logic                 zero_q;
    logic                 at_zero;
    logic                 tick;
    logic                 vis_on;
    logic [NUM_CHARS-1:0] hit;
    logic [NUM_CHARS-1:0] slot_vis;
`ifdef SPLASH_BLINK_EN
    logic                 vis_q, vis_d;
    logic [TOG_W-1:0]     tog_q, tog_d;

    assign vis_on = vis_q;
`else
    assign vis_on = 1'b1;
`endif

    assign at_zero = (VGA_HORZ_COORD == '0) && (VGA_VERT_COORD == '0);
    assign tick    = at_zero && !zero_q;

    for (genvar i = 0; i < NUM_CHARS; i++) begin : g_slot
        glyph_slot_render #(
            .ORG_X (ORIGIN_X + i * CHAR_PITCH),
            .ORG_Y (ORIGIN_Y)
        ) u_slot (
            .x_i    (VGA_HORZ_COORD),
            .y_i    (VGA_VERT_COORD),
            .code_i (codes_q[CODE_W*i +: CODE_W]),
            .hit_o  (hit[i])
        );
        assign slot_vis[i] = (shown_q > SH_W'(i)) && vis_on;
    end

    // Sequencer next state; counters only move on a frame tick.
    always_comb begin
        state_d = state_q;
        shown_d = shown_q;
        cnt_d   = cnt_q;
        codes_d = codes_q;
        done_d  = 1'b0;
`ifdef SPLASH_BLINK_EN
        vis_d   = vis_q;
        tog_d   = tog_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
            shown_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        codes_d = char_codes;
                        cnt_d   = '0;
                        shown_d = SH_W'(1);
                        state_d = ST_REVEAL;
`ifdef SPLASH_BLINK_EN
                        vis_d   = 1'b1;
                        tog_d   = '0;
`endif
                    end
                end
                ST_REVEAL: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(REVEAL_FRAMES - 1)) begin
                            cnt_d = '0;
                            if (shown_q == SH_W'(NUM_CHARS)) begin
                                state_d = ST_HOLD;
                            end else begin
                                shown_d = shown_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
                            cnt_d = '0;
`ifdef SPLASH_BLINK_EN
                            state_d = ST_BLINK;
                            vis_d   = 1'b0;
                            tog_d   = '0;
`else
                            state_d = ST_IDLE;
                            shown_d = '0;
                            done_d  = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`ifdef SPLASH_BLINK_EN
                ST_BLINK: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                            cnt_d = '0;
                            vis_d = ~vis_q;
                            if (tog_q == TOG_W'(TOGGLES - 1)) begin
                                state_d = ST_IDLE;
                                shown_d = '0;
                                done_d  = 1'b1;
                                vis_d   = 1'b1;
                                tog_d   = '0;
                            end else begin
                                tog_d = tog_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
        ovl_d = (state_d != ST_IDLE) && |(hit & slot_vis);
    end

    // State, counters, latched codes and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shown_q <= '0;
            cnt_q   <= '0;
            codes_q <= '0;
            done_q  <= 1'b0;
            ovl_q   <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SPLASH_BLINK_EN
            vis_q   <= 1'b0;
            tog_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shown_q <= shown_d;
            cnt_q   <= cnt_d;
            codes_q <= codes_d;
            done_q  <= done_d;
            ovl_q   <= ovl_d;
            zero_q  <= at_zero;
`ifdef SPLASH_BLINK_EN
            vis_q   <= vis_d;
            tog_q   <= tog_d;
`endif
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign overlay_on = ovl_q;

endmodule

// File: tb/tb_splash_overlay_seq.sv
// Directed bench for splash_overlay_seq (default and small configurations).
// Expected timing follows SPLASH_BLINK_EN when defined.
module tb_splash_overlay_seq;

    localparam logic [11:0] X0 = 12'd119;
    localparam logic [11:0] X1 = 12'd279;
    localparam logic [11:0] X2 = 12'd439;
    localparam logic [11:0] X6 = 12'd1079;
    localparam logic [11:0] Y0 = 12'd130;
`ifdef SPLASH_BLINK_EN
    localparam int SM_DONE  = 11;
    localparam int DEF_DONE = 808;
`else
    localparam int SM_DONE  = 7;
    localparam int DEF_DONE = 628;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_def, abort_def, start_sm, abort_sm;
    logic [41:0] codes_def;
    logic [11:0] codes_sm;
    logic [11:0] hx, hy, px, py;
    logic        ov_def, busy_def, done_def;
    logic        ov_sm, busy_sm, done_sm;
    logic        tk_done_def, tk_done_sm, tk_busy_def, tk_busy_sm;

    int checks = 0;
    int failures = 0;
    int dcnt_def = 0;
    int dcnt_sm = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_def) dcnt_def <= dcnt_def + 1;
        if (done_sm) dcnt_sm <= dcnt_sm + 1;
    end

    splash_overlay_seq u_def (
        .clk(clk), .reset(rst), .start(start_def), .abort(abort_def),
        .char_codes(codes_def), .VGA_HORZ_COORD(hx), .VGA_VERT_COORD(hy),
        .overlay_on(ov_def), .busy(busy_def), .done(done_def)
    );

    splash_overlay_seq #(
        .NUM_CHARS(2), .REVEAL_FRAMES(1), .HOLD_FRAMES(5),
        .BLINK_FRAMES(2), .BLINK_CYCLES(1)
    ) u_sm (
        .clk(clk), .reset(rst), .start(start_sm), .abort(abort_sm),
        .char_codes(codes_sm), .VGA_HORZ_COORD(hx), .VGA_VERT_COORD(hy),
        .overlay_on(ov_sm), .busy(busy_sm), .done(done_sm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hx = 12'd0;
        hy = 12'd0;
        step();
        tk_done_def = done_def;
        tk_done_sm  = done_sm;
        tk_busy_def = busy_def;
        tk_busy_sm  = busy_sm;
        hx = px;
        hy = py;
        step();
    endtask

    task automatic probe(input logic [11:0] x, input logic [11:0] y);
        hx = x;
        hy = y;
        step();
    endtask

    function automatic logic exp_sm_ov(input int k);
`ifdef SPLASH_BLINK_EN
        if (k <= 6) return 1'b1;
        if (k >= 11) return 1'b0;
        return (((k - 7) / 2) % 2) == 1;
`else
        return k <= 6;
`endif
    endfunction

    function automatic logic exp_def_ov(input int k);
        if (k < 628) return 1'b1;
`ifdef SPLASH_BLINK_EN
        if (k >= 808) return 1'b0;
        return (((k - 628) / 30) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (busy_def !== 1'b0) begin failures++; $display("FAIL reset_busy_def got=%b want=0", busy_def); end
        checks++; if (done_def !== 1'b0) begin failures++; $display("FAIL reset_done_def got=%b want=0", done_def); end
        checks++; if (ov_def !== 1'b0) begin failures++; $display("FAIL reset_ov_def got=%b want=0", ov_def); end
        checks++; if (busy_sm !== 1'b0) begin failures++; $display("FAIL reset_busy_sm got=%b want=0", busy_sm); end
        checks++; if (done_sm !== 1'b0) begin failures++; $display("FAIL reset_done_sm got=%b want=0", done_sm); end
        checks++; if (ov_sm !== 1'b0) begin failures++; $display("FAIL reset_ov_sm got=%b want=0", ov_sm); end
        rst = 1'b0;
        step();
        checks++; if (busy_def !== 1'b0) begin failures++; $display("FAIL idle_busy_def got=%b want=0", busy_def); end
    endtask

    task automatic test_glyph();
        logic [11:0] gx [11] = '{119, 119, 119, 103, 215, 207, 119, 279, 279, 240, 99};
        logic [11:0] gy [11] = '{130, 146, 162, 130, 130, 130, 226, 210, 130, 130, 130};
        logic        ge [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int d0;
        d0 = dcnt_sm;
        px = X0; py = Y0;
        codes_sm = {6'b100000, 6'b000101};
        start_sm = 1'b1;
        step();
        start_sm = 1'b0;
        codes_sm = '0;
        checks++; if (busy_sm !== 1'b1) begin failures++; $display("FAIL glyph_busy got=%b want=1", busy_sm); end
        probe(12'd279, 12'd210);
        checks++; if (ov_sm !== 1'b0) begin failures++; $display("FAIL glyph_slot1_hidden got=%b want=0", ov_sm); end
        tick();
        for (int i = 0; i < 11; i++) begin
            probe(gx[i], gy[i]);
            checks++;
            if (ov_sm !== ge[i]) begin
                failures++;
                $display("FAIL glyph_px(%0d,%0d) got=%b want=%b", gx[i], gy[i], ov_sm, ge[i]);
            end
        end
        hx = X0; hy = Y0;
        abort_sm = 1'b1;
        step();
        abort_sm = 1'b0;
        checks++; if (busy_sm !== 1'b0) begin failures++; $display("FAIL glyph_abort_busy got=%b want=0", busy_sm); end
        checks++; if (ov_sm !== 1'b0) begin failures++; $display("FAIL glyph_abort_ov got=%b want=0", ov_sm); end
        step();
        checks++; if (dcnt_sm !== d0) begin failures++; $display("FAIL glyph_abort_done got=%0d want=%0d", dcnt_sm, d0); end
    endtask

    task automatic test_small_sequence();
        int d0, done_at;
        logic busy_at;
        d0 = dcnt_sm;
        done_at = 0;
        busy_at = 1'b1;
        px = X0; py = Y0;
        codes_sm = {6'h01, 6'h01};
        start_sm = 1'b1;
        step();
        start_sm = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (tk_done_sm && done_at == 0) begin
                done_at = k;
                busy_at = tk_busy_sm;
            end
            checks++;
            if (ov_sm !== exp_sm_ov(k)) begin
                failures++;
                $display("FAIL sm_ov_tick%0d got=%b want=%b", k, ov_sm, exp_sm_ov(k));
            end
        end
        checks++; if (done_at !== SM_DONE) begin failures++; $display("FAIL sm_done_tick got=%0d want=%0d", done_at, SM_DONE); end
        checks++; if (busy_at !== 1'b0) begin failures++; $display("FAIL sm_busy_at_done got=%b want=0", busy_at); end
        checks++; if (dcnt_sm - d0 !== 1) begin failures++; $display("FAIL sm_done_count got=%0d want=1", dcnt_sm - d0); end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = dcnt_sm;
        px = X0; py = Y0;
        codes_sm = {6'h01, 6'h01};
        start_sm = 1'b1;
        step();
        codes_sm = '0;
        step();
        start_sm = 1'b0;
        probe(X0, Y0);
        checks++; if (ov_sm !== 1'b1) begin failures++; $display("FAIL b2b_codes_kept got=%b want=1", ov_sm); end
        probe(X1, Y0);
        checks++; if (ov_sm !== 1'b0) begin failures++; $display("FAIL b2b_shown_one got=%b want=0", ov_sm); end
        for (int k = 1; k <= 13; k++) tick();
        checks++; if (dcnt_sm - d0 !== 1) begin failures++; $display("FAIL b2b_done_count got=%0d want=1", dcnt_sm - d0); end
        checks++; if (busy_sm !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b want=0", busy_sm); end
    endtask

    task automatic test_start_abort();
        px = X0; py = Y0;
        codes_sm = {6'h01, 6'h01};
        start_sm = 1'b1;
        abort_sm = 1'b1;
        step();
        start_sm = 1'b0;
        abort_sm = 1'b0;
        checks++; if (busy_sm !== 1'b0) begin failures++; $display("FAIL sa_busy got=%b want=0", busy_sm); end
        for (int k = 0; k < 3; k++) tick();
        checks++; if (busy_sm !== 1'b0) begin failures++; $display("FAIL sa_busy_later got=%b want=0", busy_sm); end
        checks++; if (ov_sm !== 1'b0) begin failures++; $display("FAIL sa_ov got=%b want=0", ov_sm); end
    endtask

    task automatic test_default_reveal();
        int d0, done_at;
        logic busy_at;
        d0 = dcnt_def;
        done_at = 0;
        busy_at = 1'b1;
        px = X0; py = Y0;
        codes_def = {7{6'h01}};
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        probe(X0, Y0);
        checks++; if (ov_def !== 1'b1) begin failures++; $display("FAIL def_slot0_t0 got=%b want=1", ov_def); end
        probe(X1, Y0);
        checks++; if (ov_def !== 1'b0) begin failures++; $display("FAIL def_slot1_t0 got=%b want=0", ov_def); end
        for (int k = 1; k <= DEF_DONE + 2; k++) begin
            tick();
            if (tk_done_def && done_at == 0) begin
                done_at = k;
                busy_at = tk_busy_def;
            end
            checks++;
            if (ov_def !== exp_def_ov(k)) begin
                failures++;
                $display("FAIL def_ov_tick%0d got=%b want=%b", k, ov_def, exp_def_ov(k));
            end
            if (k == 3 || k == 4) begin
                probe(X1, Y0);
                checks++;
                if (ov_def !== (k == 4)) begin
                    failures++;
                    $display("FAIL def_slot1_tick%0d got=%b want=%b", k, ov_def, k == 4);
                end
            end
            if (k == 7 || k == 8) begin
                probe(X2, Y0);
                checks++;
                if (ov_def !== (k == 8)) begin
                    failures++;
                    $display("FAIL def_slot2_tick%0d got=%b want=%b", k, ov_def, k == 8);
                end
            end
            if (k == 23 || k == 24) begin
                probe(X6, Y0);
                checks++;
                if (ov_def !== (k == 24)) begin
                    failures++;
                    $display("FAIL def_slot6_tick%0d got=%b want=%b", k, ov_def, k == 24);
                end
            end
        end
        checks++; if (done_at !== DEF_DONE) begin failures++; $display("FAIL def_done_tick got=%0d want=%0d", done_at, DEF_DONE); end
        checks++; if (busy_at !== 1'b0) begin failures++; $display("FAIL def_busy_at_done got=%b want=0", busy_at); end
        checks++; if (dcnt_def - d0 !== 1) begin failures++; $display("FAIL def_done_count got=%0d want=1", dcnt_def - d0); end
    endtask

    task automatic test_abort();
        int d0;
        d0 = dcnt_def;
        px = X0; py = Y0;
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        probe(X0, Y0);
        checks++; if (ov_def !== 1'b1) begin failures++; $display("FAIL abort_pre_ov got=%b want=1", ov_def); end
        abort_def = 1'b1;
        step();
        abort_def = 1'b0;
        checks++; if (busy_def !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy_def); end
        checks++; if (ov_def !== 1'b0) begin failures++; $display("FAIL abort_ov got=%b want=0", ov_def); end
        for (int k = 0; k < 5; k++) tick();
        checks++; if (dcnt_def !== d0) begin failures++; $display("FAIL abort_no_done got=%0d want=%0d", dcnt_def, d0); end
        checks++; if (ov_def !== 1'b0) begin failures++; $display("FAIL abort_ov_later got=%b want=0", ov_def); end
    endtask

    task automatic test_frame_tick();
        px = X0; py = Y0;
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        hx = 12'd0; hy = 12'd0;
        for (int k = 0; k < 5; k++) step();
        hx = px; hy = py;
        step();
        tick();
        tick();
        probe(X1, Y0);
        checks++; if (ov_def !== 1'b0) begin failures++; $display("FAIL ftick_three got=%b want=0", ov_def); end
        tick();
        probe(X1, Y0);
        checks++; if (ov_def !== 1'b1) begin failures++; $display("FAIL ftick_four got=%b want=1", ov_def); end
        abort_def = 1'b1;
        step();
        abort_def = 1'b0;
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = dcnt_def;
        px = X0; py = Y0;
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        probe(X0, Y0);
        checks++; if (ov_def !== 1'b1) begin failures++; $display("FAIL rmid_pre_ov got=%b want=1", ov_def); end
        checks++; if (busy_def !== 1'b1) begin failures++; $display("FAIL rmid_pre_busy got=%b want=1", busy_def); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy_def !== 1'b0) begin failures++; $display("FAIL rmid_async_busy got=%b want=0", busy_def); end
        checks++; if (ov_def !== 1'b0) begin failures++; $display("FAIL rmid_async_ov got=%b want=0", ov_def); end
        checks++; if (done_def !== 1'b0) begin failures++; $display("FAIL rmid_async_done got=%b want=0", done_def); end
        step();
        rst = 1'b0;
        step();
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        probe(X0, Y0);
        checks++; if (ov_def !== 1'b1) begin failures++; $display("FAIL rmid_restart_slot0 got=%b want=1", ov_def); end
        probe(X1, Y0);
        checks++; if (ov_def !== 1'b0) begin failures++; $display("FAIL rmid_restart_slot1 got=%b want=0", ov_def); end
        checks++; if (dcnt_def !== d0) begin failures++; $display("FAIL rmid_no_done got=%0d want=%0d", dcnt_def, d0); end
        abort_def = 1'b1;
        step();
        abort_def = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_def = 1'b0; abort_def = 1'b0;
        start_sm = 1'b0; abort_sm = 1'b0;
        codes_def = '0; codes_sm = '0;
        hx = 12'd5; hy = 12'd5;
        px = X0; py = Y0;
        tk_done_def = 1'b0; tk_done_sm = 1'b0;
        tk_busy_def = 1'b0; tk_busy_sm = 1'b0;
        test_reset();
        test_glyph();
        test_small_sequence();
        test_back_to_back();
        test_start_abort();
        test_default_reveal();
        test_abort();
        test_frame_tick();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
